// File: rtl/uop_pkg.sv
// rtl/uop_pkg.sv - shared types and helpers for the uop_block scheduler
package uop_pkg;

    localparam int SCHED_MAX_REQ = 16;
    localparam int SCHED_ID_MAXW = $clog2(SCHED_MAX_REQ);

    function automatic int sched_idw(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // id is sized for the largest supported requester count; users keep the low sched_idw(N_REQ) bits
    typedef struct packed {
        logic                     valid;
        logic [SCHED_ID_MAXW-1:0] id;
    } sched_tag_t;

endpackage

// File: rtl/uop_block_sched_if.sv
// rtl/uop_block_sched_if.sv - request, datapath and response signals of the uop_block scheduler
interface uop_block_sched_if
    import uop_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 64
);
    localparam int IDW = sched_idw(N_REQ);
    localparam int SW  = $clog2(W);

    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [N_REQ*W-1:0]  req_src_i;
    logic [N_REQ*SW-1:0] req_shamt_i;
    logic [W-1:0]        dp_src_o;
    logic [SW-1:0]       dp_shamt_o;
    logic [W-1:0]        dp_dst_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [IDW-1:0]      rsp_id_o;
    logic [W-1:0]        rsp_data_o;
    logic                busy_o;

    modport master (
        output req_valid_i, req_src_i, req_shamt_i, dp_dst_i, rsp_ready_i,
        input  req_ready_o, dp_src_o, dp_shamt_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_src_i, req_shamt_i, dp_dst_i, rsp_ready_i,
        output req_ready_o, dp_src_o, dp_shamt_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
    );

endinterface

// File: rtl/uop_rr_arb.sv
// rtl/uop_rr_arb.sv - round-robin arbiter with enable, one-hot grant and rotating pointer
module uop_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    int            idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_next   = PW'((idx + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/uop_block_sched.sv
// rtl/uop_block_sched.sv - round-robin issue into a fixed-latency datapath with credit-protected response FIFO
module uop_block_sched
    import uop_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W         = 64,
    parameter int LAT       = 3,
    parameter int RSP_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    uop_block_sched_if.slave bus
);
    localparam int IDW = sched_idw(N_REQ);
    localparam int SW  = $clog2(W);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int AW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [N_REQ-1:0]         grant;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic [CW-1:0]            credits;
    logic [CW-1:0]            count;
    logic [W-1:0]             sel_src;
    logic [SW-1:0]            sel_shamt;
    logic [SCHED_ID_MAXW-1:0] sel_id;
    logic [W-1:0]             dp_src;
    logic [SW-1:0]            dp_shamt;
    sched_tag_t               tags [LAT];
    logic                     any_tag;
    logic [W-1:0]             fifo_data [RSP_DEPTH];
    logic [IDW-1:0]           fifo_id [RSP_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(RSP_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // credits count free FIFO slots not yet claimed by an in-flight op
    uop_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (!rst && (credits != '0)),
        .req   (bus.req_valid_i),
        .grant (grant)
    );

    assign bus.req_ready_o = grant;
    assign issue           = |grant;

    always_comb begin
        sel_src   = '0;
        sel_shamt = '0;
        sel_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_src   = bus.req_src_i[k*W +: W];
                sel_shamt = bus.req_shamt_i[k*SW +: SW];
                sel_id    = SCHED_ID_MAXW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_src   <= '0;
            dp_shamt <= '0;
        end else if (issue) begin
            dp_src   <= sel_src;
            dp_shamt <= sel_shamt;
        end
    end

    assign bus.dp_src_o   = dp_src;
    assign bus.dp_shamt_o = dp_shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) tags[s] <= '0;
        end else begin
            tags[0] <= '{valid: issue, id: sel_id};
            for (int s = 1; s < LAT; s++) tags[s] <= tags[s-1];
        end
    end

    always_comb begin
        any_tag = 1'b0;
        for (int s = 0; s < LAT; s++) any_tag = any_tag | tags[s].valid;
    end

    assign push = tags[LAT-1].valid;
    assign pop  = (count != '0) && bus.rsp_ready_i;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.dp_dst_i;
            fifo_id[wr_ptr]   <= tags[LAT-1].id[IDW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            credits <= CW'(RSP_DEPTH);
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({issue, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    assign bus.rsp_valid_o = (count != '0);
    assign bus.rsp_data_o  = bus.rsp_valid_o ? fifo_data[rd_ptr] : '0;
    assign bus.rsp_id_o    = bus.rsp_valid_o ? fifo_id[rd_ptr] : '0;
    assign bus.busy_o      = any_tag || (count != '0);

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CW'(RSP_DEPTH))));

    tag_id_in_range: assert property (@(posedge clk) disable iff (rst)
        push |-> (int'(tags[LAT-1].id) < N_REQ));

endmodule

// File: tb/tb_uop_block_sched.sv
// tb/tb_uop_block_sched.sv - randomized scoreboard bench for uop_block_sched
module tb_uop_block_sched;
    import uop_pkg::*;

    localparam int N_REQ     = 4;
    localparam int W         = 64;
    localparam int LAT       = 3;
    localparam int RSP_DEPTH = 4;
    localparam int SW        = $clog2(W);
    localparam int IDW       = sched_idw(N_REQ);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ*W-1:0]  req_src   = '0;
    logic [N_REQ*SW-1:0] req_shamt = '0;
    logic                rsp_ready = 1'b0;
    logic [W-1:0]        dp_pipe [LAT-1];

    uop_block_sched_if #(.N_REQ(N_REQ), .W(W)) bus ();

    uop_block_sched #(.N_REQ(N_REQ), .W(W), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.req_valid_i = req_valid;
    assign bus.req_src_i   = req_src;
    assign bus.req_shamt_i = req_shamt;
    assign bus.rsp_ready_i = rsp_ready;
    assign bus.dp_dst_i    = dp_pipe[LAT-2];

    function automatic logic [W-1:0] dp_func(input logic [W-1:0] src, input logic [SW-1:0] sh);
        return src + W'(sh) + W'(1);
    endfunction

    // datapath model: result appears LAT-1 cycles after the issue register updates
    always @(posedge clk) begin
        dp_pipe[0] <= dp_func(bus.dp_src_o, bus.dp_shamt_o);
        for (int i = 1; i < LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    exp_t             exp_q [$];
    int               model_ptr = 0;
    logic [N_REQ-1:0] hs_last   = '0;

    function automatic logic [N_REQ-1:0] model_grant(input logic [N_REQ-1:0] v, input int ptr, input int outstanding);
        logic [N_REQ-1:0] g;
        g = '0;
        if (outstanding < RSP_DEPTH) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (g == '0 && v[(ptr + i) % N_REQ]) g[(ptr + i) % N_REQ] = 1'b1;
            end
        end
        return g;
    endfunction

    // reference bookkeeping: record accepted requests and retired responses
    always @(posedge clk) begin
        logic [N_REQ-1:0] hs;
        if (rst) begin
            exp_q.delete();
            model_ptr <= 0;
            hs_last   <= '0;
        end else begin
            hs = bus.req_valid_i & bus.req_ready_o;
            if (bus.rsp_valid_o && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            for (int k = 0; k < N_REQ; k++) begin
                if (hs[k]) begin
                    exp_q.push_back('{id: IDW'(k), data: dp_func(bus.req_src_i[k*W +: W], bus.req_shamt_i[k*SW +: SW])});
                    model_ptr <= (k + 1) % N_REQ;
                end
            end
            hs_last <= hs;
        end
    end

    always @(negedge clk) begin
        logic [N_REQ-1:0] eg;
        if (!rst) begin
            eg = model_grant(bus.req_valid_i, model_ptr, exp_q.size());
            check("grant", bus.req_ready_o == eg, 64'(bus.req_ready_o), 64'(eg));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", bus.rsp_valid_o == 1'b0, 64'(bus.rsp_valid_o), 64'd0);
            end else begin
                check("rsp_id", bus.rsp_id_o == exp_q[0].id, 64'(bus.rsp_id_o), 64'(exp_q[0].id));
                check("rsp_data", bus.rsp_data_o == exp_q[0].data, bus.rsp_data_o, exp_q[0].data);
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_hold
        req_stable: assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid_i[k] && !bus.req_ready_o[k]) |=>
            (bus.req_valid_i[k] && $stable(bus.req_src_i[k*W +: W])));
    end

    task automatic new_payload(input int k);
        req_src[k*W +: W]     = {$urandom, $urandom};
        req_shamt[k*SW +: SW] = SW'($urandom);
    endtask

    task automatic drive_random(input int cycles, input int pv, input int pr);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N_REQ; k++) begin
                if (!req_valid[k] || hs_last[k]) begin
                    req_valid[k] = ($urandom_range(0, 99) < pv);
                    new_payload(k);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < pr);
        end
    endtask

    task automatic settle();
        int c;
        c = 0;
        rsp_ready = 1'b1;
        do begin
            @(posedge clk); #1;
            req_valid = req_valid & ~hs_last;
            c++;
        end while ((req_valid != '0 || bus.busy_o) && c < 200);
        check("settle_idle", !bus.busy_o && req_valid == '0, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready_o == '0, 64'(bus.req_ready_o), 64'd0);
        check({tag, "_rsp_valid"}, bus.rsp_valid_o == 1'b0, 64'(bus.rsp_valid_o), 64'd0);
        check({tag, "_busy"}, bus.busy_o == 1'b0, 64'(bus.busy_o), 64'd0);
        check({tag, "_dp_src"}, bus.dp_src_o == '0, bus.dp_src_o, 64'd0);
        check({tag, "_dp_shamt"}, bus.dp_shamt_o == '0, 64'(bus.dp_shamt_o), 64'd0);
        check({tag, "_rsp_id"}, bus.rsp_id_o == '0, 64'(bus.rsp_id_o), 64'd0);
        check({tag, "_rsp_data"}, bus.rsp_data_o == '0, bus.rsp_data_o, 64'd0);
    endtask

    initial begin
        int n;
        int nh;

        // reset state, with requests pending to show ready is suppressed
        req_valid = '1;
        for (int k = 0; k < N_REQ; k++) new_payload(k);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        req_valid = '0;
        rst = 1'b0;

        // single op: src 5, shamt 0 -> result 6 from requester 0
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_src[0 +: W] = 64'h5;
        req_shamt[0 +: SW] = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("single_hs", hs_last == 4'b0001, 64'(hs_last), 64'h1);
        req_valid = '0;
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("single_latency", n == LAT, 64'(n), 64'(LAT));
        check("single_id", bus.rsp_id_o == '0, 64'(bus.rsp_id_o), 64'd0);
        check("single_data", bus.rsp_data_o == 64'h6, bus.rsp_data_o, 64'h6);
        @(posedge clk); #1;
        check("single_busy_clear", bus.busy_o == 1'b0, 64'(bus.busy_o), 64'd0);

        // all requesters valid continuously, responses drained every cycle
        req_valid = '1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N_REQ; k++) if (hs_last[k]) new_payload(k);
        end
        settle();

        // backpressure: credits run out after RSP_DEPTH issues
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        new_payload(1);
        nh = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (hs_last[1]) begin
                nh++;
                new_payload(1);
            end
        end
        check("bp_issue_count", nh == RSP_DEPTH, 64'(nh), 64'(RSP_DEPTH));
        check("bp_ready_low", bus.req_ready_o == '0, 64'(bus.req_ready_o), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_same_cycle_blocked", hs_last == '0, 64'(hs_last), 64'd0);
        @(posedge clk); #1;
        check("bp_freed_issue", hs_last == 4'b0010, 64'(hs_last), 64'h2);
        new_payload(1);
        nh = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (hs_last[1]) nh++;
        end
        check("bp_no_extra_issue", nh == 0, 64'(nh), 64'd0);
        settle();

        // wrap-around: move pointer to 3, then lone req2 must wrap, then pointer is 3 again
        req_valid = 4'b0100;
        new_payload(2);
        @(posedge clk); #1;
        check("wrap_first", hs_last == 4'b0100, 64'(hs_last), 64'h4);
        new_payload(2);
        @(posedge clk); #1;
        check("wrap_grant2", hs_last == 4'b0100, 64'(hs_last), 64'h4);
        req_valid = 4'b1001;
        new_payload(0);
        new_payload(3);
        @(posedge clk); #1;
        check("wrap_ptr3", hs_last == 4'b1000, 64'(hs_last), 64'h8);
        req_valid = req_valid & ~hs_last;
        settle();

        // random traffic, light then heavy backpressure
        drive_random(400, 50, 70);
        drive_random(200, 80, 20);
        settle();

        // reset with one response buffered and two ops in flight
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) new_payload(k);
        nh = 0;
        n = 0;
        while (nh < 3 && n < 10) begin
            @(posedge clk); #1;
            nh += $countones(hs_last);
            req_valid = req_valid & ~hs_last;
            n++;
        end
        check("midrst_issued", nh == 3, 64'(nh), 64'd3);
        @(posedge clk); #1;
        check("midrst_buffered", bus.rsp_valid_o == 1'b1, 64'(bus.rsp_valid_o), 64'd1);
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o) n++;
        end
        check("midrst_no_stale", n == 0, 64'(n), 64'd0);
        req_valid = 4'b1000;
        new_payload(3);
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~hs_last;
            n++;
        end
        check("midrst_fresh_valid", bus.rsp_valid_o == 1'b1, 64'(bus.rsp_valid_o), 64'd1);
        check("midrst_fresh_id", bus.rsp_id_o == 2'd3, 64'(bus.rsp_id_o), 64'd3);
        settle();
        check("scoreboard_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
